// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch-port, data-port and memory-side signals of mem_port_arbiter.
//   fetch : if_req, if_addr -> if_rdata, if_ack, stall_f
//   data  : d_req, d_we, d_addr, d_wdata, d_bsel -> d_rdata, d_ack, stall_m
//   memory: mem_en, mem_we, mem_addr, mem_wdata, mem_bsel <- mem_rdata
// Modport slave is the arbiter's view; modport master is the view of the
// surrounding pipeline plus memory (the side that drives requests and mem_rdata).
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [1:0]            d_bsel;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ack;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [1:0]            mem_bsel;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  stall_f;
  logic                  stall_m;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_bsel, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_bsel,
    output stall_f, stall_m
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_bsel, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_bsel,
    input  stall_f, stall_m
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// fetch port and the data port of the core.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : mem_port_arbiter_if.slave carrying both request ports, the
//              memory interface and the two stall outputs
// One access at a time: IDLE (arbitrate) -> ISSUE (mem_en) -> WAIT (latency)
// -> RESP (ack). Data wins ties unless fetch has been passed over STARVE_LIMIT
// times in a row. Request ack arrives MEM_LATENCY+2 cycles after the grant cycle.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_LIMIT must be >= 1");
    end
  endgenerate

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] BSEL_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_reg;
  logic                  owner_d_reg;   // 1 = data port owns the access
  logic                  acc_we_reg;    // access is a store (kept past ISSUE)
  logic [CNT_W-1:0]      cnt_reg;
  logic [STV_W-1:0]      starve_reg;

  logic                  if_ack_reg;
  logic                  d_ack_reg;
  logic [DATA_WIDTH-1:0] if_rdata_reg;
  logic [DATA_WIDTH-1:0] d_rdata_reg;
  logic                  mem_en_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [1:0]            mem_bsel_reg;

  // Data wins a tie only while fetch has not yet hit its starvation limit.
  logic grant_d;
  always_comb begin
    grant_d = bus.d_req && (!bus.if_req || (starve_reg != STV_W'(STARVE_LIMIT)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_d_reg   <= 1'b1;
      acc_we_reg    <= 1'b0;
      cnt_reg       <= '0;
      starve_reg    <= '0;
      if_ack_reg    <= 1'b0;
      d_ack_reg     <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_bsel_reg  <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            // The memory-side registers are loaded here so that they present
            // the owner's request during exactly the ISSUE cycle.
            state_reg   <= ISSUE;
            owner_d_reg <= grant_d;
            mem_en_reg  <= 1'b1;
            if (grant_d) begin
              acc_we_reg    <= bus.d_we;
              mem_we_reg    <= bus.d_we;
              mem_addr_reg  <= bus.d_addr;
              mem_wdata_reg <= bus.d_wdata;
              mem_bsel_reg  <= bus.d_bsel;
              if (bus.if_req) begin
                if (starve_reg != STV_W'(STARVE_LIMIT)) begin
                  starve_reg <= starve_reg + 1'b1;
                end
              end else begin
                starve_reg <= '0;
              end
            end else begin
              acc_we_reg   <= 1'b0;
              mem_we_reg   <= 1'b0;
              mem_addr_reg <= bus.if_addr;
              mem_bsel_reg <= BSEL_WORD;
              starve_reg   <= '0;
            end
          end
        end

        ISSUE: begin
          mem_en_reg <= 1'b0;
          mem_we_reg <= 1'b0;
          cnt_reg    <= CNT_W'(MEM_LATENCY - 1);
          state_reg  <= WAIT;
        end

        WAIT: begin
          if (cnt_reg == '0) begin
            // mem_rdata is valid in this cycle.
            state_reg <= RESP;
            if (owner_d_reg) begin
              d_rdata_reg <= acc_we_reg ? '0 : bus.mem_rdata;
              d_ack_reg   <= 1'b1;
            end else begin
              if_rdata_reg <= bus.mem_rdata;
              if_ack_reg   <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        RESP: begin
          if_ack_reg <= 1'b0;
          d_ack_reg  <= 1'b0;
          state_reg  <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.if_ack    = if_ack_reg;
  assign bus.d_ack     = d_ack_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_bsel  = mem_bsel_reg;

  assign bus.stall_f = bus.if_req & ~if_ack_reg;
  assign bus.stall_m = bus.d_req & ~d_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LATENCY=2 instance carries most
// scenarios and a MEM_LATENCY=1 instance checks the short-latency timing.
// Expected memory accesses and acks are queued as stimulus is applied and
// matched by a monitor as the DUT produces them.
module tb_mem_port_arbiter;

  localparam logic [1:0] BS_BYTE = 2'b00;
  localparam logic [1:0] BS_HALF = 2'b01;
  localparam logic [1:0] BS_WORD = 2'b10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus  ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4))
    dut (.clk(clk), .rst(rst), .bus(bus));
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Memory contents: fixed function of the address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0081_0093;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Fixed-latency memory models; a poison word is returned outside valid slots.
  logic [31:0] pipe2 [2];
  logic [31:0] pipe1 [1];
  always @(posedge clk) begin
    pipe2[0] <= (bus.mem_en && !bus.mem_we) ? mem_val(bus.mem_addr) : 32'hBAD0_BAD0;
    pipe2[1] <= pipe2[0];
    pipe1[0] <= (bus1.mem_en && !bus1.mem_we) ? mem_val(bus1.mem_addr) : 32'hBAD1_BAD1;
  end
  assign bus.mem_rdata  = pipe2[1];
  assign bus1.mem_rdata = pipe1[0];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } ack_t;
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  bsel;
  } acc_t;

  ack_t ack_q[$];
  acc_t acc_q[$];
  logic prev_ack = 1'b0;

  // Scoreboard monitor for the MEM_LATENCY=2 instance.
  always @(negedge clk) begin
    ack_t e;
    acc_t a;
    if (bus.if_ack || bus.d_ack) begin
      check("single_ack", {63'd0, bus.if_ack & bus.d_ack}, 64'd0);
      check("ack_gap", {63'd0, prev_ack}, 64'd0);
      if (ack_q.size() == 0) begin
        check("spurious_ack", {62'd0, bus.if_ack, bus.d_ack}, 64'd0);
      end else begin
        e = ack_q.pop_front();
        check("ack_port", {63'd0, bus.d_ack}, {63'd0, e.is_d});
        check("ack_data", e.is_d ? bus.d_rdata : bus.if_rdata, e.data);
        $display("ack  port=%s data=%08h", bus.d_ack ? "D" : "I",
                 bus.d_ack ? bus.d_rdata : bus.if_rdata);
      end
    end
    prev_ack <= bus.if_ack | bus.d_ack;
    if (bus.mem_en) begin
      if (acc_q.size() == 0) begin
        check("spurious_mem_en", {63'd0, bus.mem_en}, 64'd0);
      end else begin
        a = acc_q.pop_front();
        check("acc_we", {63'd0, bus.mem_we}, {63'd0, a.we});
        check("acc_addr", bus.mem_addr, a.addr);
        check("acc_bsel", bus.mem_bsel, a.bsel);
        if (a.we) check("acc_wdata", bus.mem_wdata, a.wdata);
        $display("mem  we=%0d addr=%08h wdata=%08h bsel=%0d",
                 bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_bsel);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        is_d;
    logic [31:0] ea;
    rst = 1'b1;
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.d_req = 1'b0;   bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_bsel = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0;
    bus1.d_req = 1'b0;  bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_bsel = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_ack", bus.if_ack, 0);
    check("rst_d_ack", bus.d_ack, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_en_l1", bus1.mem_en, 0);
    tick();
    rst = 1'b0;

    // Fetch only
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    ack_q.push_back('{1'b0, 32'h0081_0093});
    acc_q.push_back('{1'b0, 32'h10, 32'h0, BS_WORD});
    @(negedge clk);
    check("f_stall_t0", bus.stall_f, 1);
    check("f_mem_en_t0", bus.mem_en, 0);
    tick(); @(negedge clk);
    check("f_mem_en_t1", bus.mem_en, 1);
    check("f_mem_addr_t1", bus.mem_addr, 32'h10);
    check("f_mem_we_t1", bus.mem_we, 0);
    for (int i = 2; i <= 3; i++) begin
      tick(); @(negedge clk);
      check("f_stall_wait", bus.stall_f, 1);
      check("f_ack_wait", bus.if_ack, 0);
      check("f_mem_en_wait", bus.mem_en, 0);
    end
    tick(); @(negedge clk);
    check("f_ack_t4", bus.if_ack, 1);
    check("f_rdata_t4", bus.if_rdata, 32'h0081_0093);
    check("f_stall_t4", bus.stall_f, 0);
    tick();
    bus.if_req = 1'b0;

    // Store
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_bsel = BS_WORD;
    ack_q.push_back('{1'b1, 32'h0});
    acc_q.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF, BS_WORD});
    tick(); @(negedge clk);
    check("s_mem_en_t1", bus.mem_en, 1);
    check("s_mem_we_t1", bus.mem_we, 1);
    check("s_mem_wdata_t1", bus.mem_wdata, 32'hDEAD_BEEF);
    tick(); tick(); @(negedge clk);
    check("s_stall_m_t3", bus.stall_m, 1);
    check("s_mem_we_t3", bus.mem_we, 0);
    tick(); @(negedge clk);
    check("s_d_ack_t4", bus.d_ack, 1);
    check("s_d_rdata_t4", bus.d_rdata, 0);
    check("s_if_ack_t4", bus.if_ack, 0);
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0;

    // Both requesting continuously: expect D,D,D,D,I,D,D,D,D,I
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000; bus.d_bsel = BS_HALF;
    for (int k = 0; k < 10; k++) begin
      is_d = (k % 5) != 4;
      ea = is_d ? bus.d_addr : bus.if_addr;
      ack_q.push_back('{is_d, mem_val(ea)});
      acc_q.push_back('{1'b0, ea, 32'h0, is_d ? BS_HALF : BS_WORD});
      tick(); @(negedge clk);
      check("arb_grant_addr", bus.mem_addr, ea);
      tick(); tick(); tick(); @(negedge clk);
      check("arb_d_ack", bus.d_ack, is_d);
      check("arb_if_ack", bus.if_ack, !is_d);
      tick();
      if (is_d) bus.d_addr = bus.d_addr + 32'd4;
      else      bus.if_addr = bus.if_addr + 32'd4;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;

    // Reset during WAIT of a load, then a fresh access
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_bsel = BS_WORD;
    acc_q.push_back('{1'b0, 32'h300, 32'h0, BS_WORD});
    tick(); tick();
    rst = 1'b1;
    #1;
    check("r_mem_en", bus.mem_en, 0);
    check("r_if_ack", bus.if_ack, 0);
    check("r_d_ack", bus.d_ack, 0);
    check("r_if_rdata", bus.if_rdata, 0);
    check("r_d_rdata", bus.d_rdata, 0);
    tick(); tick(); @(negedge clk);
    check("r_d_ack_held", bus.d_ack, 0);
    tick();
    rst = 1'b0;
    ack_q.push_back('{1'b1, mem_val(32'h300)});
    acc_q.push_back('{1'b0, 32'h300, 32'h0, BS_WORD});
    tick(); @(negedge clk);
    check("r2_mem_en_t1", bus.mem_en, 1);
    tick(); tick(); @(negedge clk);
    check("r2_d_ack_t3", bus.d_ack, 0);
    tick(); @(negedge clk);
    check("r2_d_ack_t4", bus.d_ack, 1);
    check("r2_d_rdata_t4", bus.d_rdata, mem_val(32'h300));
    tick();
    bus.d_req = 1'b0;

    // Data request dropped during WAIT with fetch pending
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400; bus.d_bsel = BS_BYTE;
    acc_q.push_back('{1'b0, 32'h400, 32'h0, BS_BYTE});
    ack_q.push_back('{1'b1, mem_val(32'h400)});
    tick(); tick();
    bus.d_req = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    acc_q.push_back('{1'b0, 32'h40, 32'h0, BS_WORD});
    ack_q.push_back('{1'b0, mem_val(32'h40)});
    @(negedge clk);
    check("dr_stall_f", bus.stall_f, 1);
    tick(); tick(); @(negedge clk);
    check("dr_d_ack_t4", bus.d_ack, 1);
    tick(); @(negedge clk);
    check("dr_d_ack_t5", bus.d_ack, 0);
    check("dr_mem_en_t5", bus.mem_en, 0);
    tick(); @(negedge clk);
    check("dr_mem_en_t6", bus.mem_en, 1);
    check("dr_mem_addr_t6", bus.mem_addr, 32'h40);
    tick(); tick(); tick(); @(negedge clk);
    check("dr_if_ack_t9", bus.if_ack, 1);
    check("dr_if_rdata_t9", bus.if_rdata, mem_val(32'h40));
    tick();
    bus.if_req = 1'b0;

    // MEM_LATENCY=1 instance: single fetch
    tick();
    bus1.if_req = 1'b1; bus1.if_addr = 32'h20;
    @(negedge clk);
    check("l1_mem_en_t0", bus1.mem_en, 0);
    tick(); @(negedge clk);
    check("l1_mem_en_t1", bus1.mem_en, 1);
    check("l1_mem_addr_t1", bus1.mem_addr, 32'h20);
    tick(); @(negedge clk);
    check("l1_ack_t2", bus1.if_ack, 0);
    tick(); @(negedge clk);
    check("l1_ack_t3", bus1.if_ack, 1);
    check("l1_rdata_t3", bus1.if_rdata, mem_val(32'h20));
    $display("ack  port=I data=%08h (latency-1 instance)", bus1.if_rdata);
    tick();
    bus1.if_req = 1'b0;

    repeat (3) tick();
    check("ack_q_drained", ack_q.size(), 0);
    check("acc_q_drained", acc_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
